// File: rtl/uart_cfg.sv
// -----------------------------------------------------------------------------
// uart_cfg -- parametrised full-duplex UART transceiver.
//
// Frame on the wire: start bit (0), D_BITS data bits LSB first, an optional
// parity bit, then STOP_BITS stop bits (1). TX and RX run independently and
// share only the clock and reset.
//
// Parameters:
//   D_BITS        data bits per frame (5..16)
//   CLKS_PER_BIT  clock cycles per serial bit (>= 4)
//   PARITY        0 = none, 1 = odd, 2 = even
//   STOP_BITS     1 or 2
//
// Ports:
//   i_clk          clock
//   reset          synchronous, active-high
//   i_data         TX word, captured when a request is accepted
//   i_tx_enable    TX request
//   o_tx           serial out, idle high
//   o_tx_rdy       TX idle; a request is accepted while this is high
//   o_tx_done      one-cycle pulse at the end of the last stop bit
//   i_rx           serial in, asynchronous to i_clk
//   o_data         last correctly received word
//   o_dvalid       one-cycle pulse, o_data updated
//   o_parity_err   one-cycle pulse, parity mismatch on a received frame
//   o_frame_err    one-cycle pulse, a stop bit was sampled low
//   o_tx_state     TX FSM state (debug)
//   o_rx_state     RX FSM state (debug)
//
// TX handshake: a word is transferred on any cycle where i_tx_enable and
// o_tx_rdy are both high. o_tx_rdy drops the following cycle and stays low
// until the frame has completed; requests made while it is low are dropped,
// not queued. o_tx_rdy rises in the same cycle as o_tx_done, and a new word
// may be transferred in that very cycle.
// -----------------------------------------------------------------------------
module uart_cfg #(
    parameter int D_BITS       = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              i_clk,
    input  logic              reset,
    input  logic [D_BITS-1:0] i_data,
    input  logic              i_tx_enable,
    output logic              o_tx,
    output logic              o_tx_rdy,
    output logic              o_tx_done,
    input  logic              i_rx,
    output logic [D_BITS-1:0] o_data,
    output logic              o_dvalid,
    output logic              o_parity_err,
    output logic              o_frame_err,
    output logic [2:0]        o_tx_state,
    output logic [2:0]        o_rx_state
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(D_BITS + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(D_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam bit            HAS_PAR   = (PARITY != 0);
    localparam bit            ODD_PAR   = (PARITY == 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_e;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_e         tx_state_q, tx_state_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]     tx_bit_q, tx_bit_d;
    logic [D_BITS-1:0] tx_shift_q, tx_shift_d;
    logic              tx_par_q, tx_par_d;
    logic              tx_line_q, tx_line_d;
    logic              tx_done_q, tx_done_d;

    always_ff @(posedge i_clk) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_line_q  <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_line_q  <= tx_line_d;
            tx_done_q  <= tx_done_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_done_d  = 1'b0;

        case (tx_state_q)
            TX_IDLE: begin
                if (i_tx_enable) begin
                    tx_shift_d = i_data;
                    tx_par_d   = (^i_data) ^ ODD_PAR;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == DATA_LAST) begin
                        tx_bit_d   = '0;
                        tx_state_d = HAS_PAR ? TX_PARITY : TX_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_PARITY: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                // tx_bit counts stop bits here so two stop bits reuse one state.
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == STOP_LAST) begin
                        tx_bit_d   = '0;
                        tx_done_d  = 1'b1;
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        // The line is registered, so it is decoded from the next state: it
        // changes on exactly the edge where the FSM enters a new bit.
        case (tx_state_d)
            TX_START:  tx_line_d = 1'b0;
            TX_DATA:   tx_line_d = tx_shift_d[0];
            TX_PARITY: tx_line_d = tx_par_d;
            default:   tx_line_d = 1'b1;
        endcase
    end

    assign o_tx       = tx_line_q;
    assign o_tx_rdy   = (tx_state_q == TX_IDLE);
    assign o_tx_done  = tx_done_q;
    assign o_tx_state = tx_state_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic              rx_meta_q, rx_sync_q;
    rx_state_e         rx_state_q, rx_state_d;
    logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]     rx_bit_q, rx_bit_d;
    logic [D_BITS-1:0] rx_shift_q, rx_shift_d;
    logic              rx_perr_q, rx_perr_d;
    logic [D_BITS-1:0] rx_word_q, rx_word_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_par_err_q, rx_par_err_d;
    logic              rx_frm_err_q, rx_frm_err_d;

    // Two-flop synchroniser; reset high so a reset never looks like a start.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_perr_q    <= 1'b0;
            rx_word_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_par_err_q <= 1'b0;
            rx_frm_err_q <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_perr_q    <= rx_perr_d;
            rx_word_q    <= rx_word_d;
            rx_valid_q   <= rx_valid_d;
            rx_par_err_q <= rx_par_err_d;
            rx_frm_err_q <= rx_frm_err_d;
        end
    end

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_perr_d    = rx_perr_q;
        rx_word_d    = rx_word_q;
        rx_valid_d   = 1'b0;
        rx_par_err_d = 1'b0;
        rx_frm_err_d = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                // Re-check the line half a bit in; from here on every sample
                // lands one full bit later, i.e. near mid-bit.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_bit_d   = '0;
                        rx_perr_d  = 1'b0;
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[D_BITS-1:1]};
                    if (rx_bit_q == DATA_LAST) begin
                        rx_bit_d   = '0;
                        rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_PARITY: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_perr_d  = (^rx_shift_q) ^ rx_sync_q ^ ODD_PAR;
                    rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    if (!rx_sync_q) begin
                        // Framing error takes priority over a parity error.
                        rx_frm_err_d = 1'b1;
                        rx_bit_d     = '0;
                        rx_state_d   = RX_WAIT_HIGH;
                    end else if (rx_bit_q == STOP_LAST) begin
                        rx_bit_d   = '0;
                        rx_state_d = RX_IDLE;
                        if (rx_perr_q) begin
                            rx_par_err_d = 1'b1;
                        end else begin
                            rx_word_d  = rx_shift_q;
                            rx_valid_d = 1'b1;
                        end
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_WAIT_HIGH: begin
                // Sit out a break: a low line here must not start a new frame.
                if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign o_data       = rx_word_q;
    assign o_dvalid     = rx_valid_q;
    assign o_parity_err = rx_par_err_q;
    assign o_frame_err  = rx_frm_err_q;
    assign o_rx_state   = rx_state_q;

endmodule

// File: tb/tb_uart_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_cfg -- directed testbench for uart_cfg.
//
// Four instances, all 8 data bits and 8 clocks per bit:
//   [0] no parity, 1 stop   (loopback, framing/break, false start)
//   [1] even parity, 1 stop (parity loopback, parity error)
//   [2] odd parity, 1 stop  (parity loopback)
//   [3] no parity, 2 stop   (busy, back-to-back, reset mid-frame)
// Each RX input is either looped back from its own TX or driven by the bench.
// -----------------------------------------------------------------------------
module tb_uart_cfg;

    localparam int CPB = 8;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] tx_en = 4'b0000;
    logic [3:0] loop  = 4'b0000;
    logic [3:0] drv   = 4'b1111;
    logic [7:0] din [4];

    wire  [3:0] tx, rdy, done, dv, pe, fe;
    wire  [7:0] dout [4];
    wire  [2:0] tx_st [4];
    wire  [2:0] rx_st [4];
    wire  [3:0] rx_in = (loop & tx) | (~loop & drv);

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int dv_cnt [4] = '{default: 0};
    int pe_cnt [4] = '{default: 0};
    int fe_cnt [4] = '{default: 0};
    logic [7:0] got_d [$];

    uart_cfg #(.D_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u_a (
        .i_clk(clk), .reset(reset), .i_data(din[0]), .i_tx_enable(tx_en[0]),
        .o_tx(tx[0]), .o_tx_rdy(rdy[0]), .o_tx_done(done[0]), .i_rx(rx_in[0]),
        .o_data(dout[0]), .o_dvalid(dv[0]), .o_parity_err(pe[0]), .o_frame_err(fe[0]),
        .o_tx_state(tx_st[0]), .o_rx_state(rx_st[0]));

    uart_cfg #(.D_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u_even (
        .i_clk(clk), .reset(reset), .i_data(din[1]), .i_tx_enable(tx_en[1]),
        .o_tx(tx[1]), .o_tx_rdy(rdy[1]), .o_tx_done(done[1]), .i_rx(rx_in[1]),
        .o_data(dout[1]), .o_dvalid(dv[1]), .o_parity_err(pe[1]), .o_frame_err(fe[1]),
        .o_tx_state(tx_st[1]), .o_rx_state(rx_st[1]));

    uart_cfg #(.D_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u_odd (
        .i_clk(clk), .reset(reset), .i_data(din[2]), .i_tx_enable(tx_en[2]),
        .o_tx(tx[2]), .o_tx_rdy(rdy[2]), .o_tx_done(done[2]), .i_rx(rx_in[2]),
        .o_data(dout[2]), .o_dvalid(dv[2]), .o_parity_err(pe[2]), .o_frame_err(fe[2]),
        .o_tx_state(tx_st[2]), .o_rx_state(rx_st[2]));

    uart_cfg #(.D_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2)) u_s2 (
        .i_clk(clk), .reset(reset), .i_data(din[3]), .i_tx_enable(tx_en[3]),
        .o_tx(tx[3]), .o_tx_rdy(rdy[3]), .o_tx_done(done[3]), .i_rx(rx_in[3]),
        .o_data(dout[3]), .o_dvalid(dv[3]), .o_parity_err(pe[3]), .o_frame_err(fe[3]),
        .o_tx_state(tx_st[3]), .o_rx_state(rx_st[3]));

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- output event monitor ----------------
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (dv[k] === 1'b1) dv_cnt[k]++;
            if (pe[k] === 1'b1) pe_cnt[k]++;
            if (fe[k] === 1'b1) fe_cnt[k]++;
        end
        if (dv[3] === 1'b1) got_d.push_back(dout[3]);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hand a word to TX k once it is ready; returns the cycle count at accept.
    task automatic accept(input int k, input logic [7:0] val, output int acc_cyc);
        int w;
        w = 0;
        @(negedge clk);
        while (rdy[k] !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        din[k]   = val;
        tx_en[k] = 1'b1;
        @(posedge clk);
        #1;
        tx_en[k] = 1'b0;
        acc_cyc  = cyc;
        total_cnt++;
        if (w >= 200) $display("FAIL accept_timeout: inst %0d rdy=%b after %0d cycles, need 1", k, rdy[k], w);
        else pass_cnt++;
    endtask

    // Drive a raw frame on RX k; bits[0] goes on the line first.
    task automatic drive_bits(input int k, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            drv[k] = bits[i];
            wait_cyc(CPB);
        end
    endtask

    // Observe TX k for max_t cycles after accept (cycle 1 is the first cycle after accept).
    task automatic watch(input int k, input int max_t, input int samp_t,
                         output int low_run, output logic samp_v, output int done_at,
                         output logic rdy_done, output logic rdy_pre, output int dv_at);
        logic rdy_prev;
        low_run  = 0;
        samp_v   = 1'bx;
        done_at  = -1;
        rdy_done = 1'bx;
        rdy_pre  = 1'bx;
        dv_at    = -1;
        rdy_prev = 1'bx;
        for (int t = 1; t <= max_t; t++) begin
            @(negedge clk);
            if (tx[k] === 1'b0 && low_run == t - 1) low_run++;
            if (t == samp_t) samp_v = tx[k];
            if (done[k] === 1'b1 && done_at < 0) begin
                done_at  = t;
                rdy_done = rdy[k];
                rdy_pre  = rdy_prev;
            end
            if (dv[k] === 1'b1 && dv_at < 0) dv_at = t;
            rdy_prev = rdy[k];
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        wait_cyc(3);
        total_cnt++; if (tx[0] !== 1'b1) $display("FAIL reset_tx: got %b need 1", tx[0]); else pass_cnt++;
        total_cnt++; if (rdy[0] !== 1'b1) $display("FAIL reset_rdy: got %b need 1", rdy[0]); else pass_cnt++;
        total_cnt++; if (done[0] !== 1'b0) $display("FAIL reset_done: got %b need 0", done[0]); else pass_cnt++;
        total_cnt++; if (dout[0] !== 8'h00) $display("FAIL reset_data: got %h need 00", dout[0]); else pass_cnt++;
        total_cnt++; if (dv[0] !== 1'b0) $display("FAIL reset_dvalid: got %b need 0", dv[0]); else pass_cnt++;
        total_cnt++; if (pe[0] !== 1'b0) $display("FAIL reset_parity_err: got %b need 0", pe[0]); else pass_cnt++;
        total_cnt++; if (fe[0] !== 1'b0) $display("FAIL reset_frame_err: got %b need 0", fe[0]); else pass_cnt++;
        reset = 1'b0;
        wait_cyc(2);
    endtask

    task automatic test_loopback_8n1();
        int c, lr, da, dva, d0, e0;
        logic sv, rd, rp;
        loop[0] = 1'b1;
        d0 = dv_cnt[0];
        e0 = pe_cnt[0] + fe_cnt[0];
        accept(0, 8'hA5, c);
        watch(0, 100, 9, lr, sv, da, rd, rp, dva);
        total_cnt++; if (lr != 8) $display("FAIL lb_start_low: got %0d low cycles need 8", lr); else pass_cnt++;
        total_cnt++; if (sv !== 1'b1) $display("FAIL lb_bit0: got %b need 1", sv); else pass_cnt++;
        total_cnt++; if (da != 81) $display("FAIL lb_done_cycle: got %0d need 81", da); else pass_cnt++;
        total_cnt++; if (rd !== 1'b1) $display("FAIL lb_rdy_at_done: got %b need 1", rd); else pass_cnt++;
        total_cnt++; if (rp !== 1'b0) $display("FAIL lb_rdy_before_done: got %b need 0", rp); else pass_cnt++;
        total_cnt++; if (dva < 78 || dva > 80) $display("FAIL lb_dvalid_latency: got %0d need 78..80", dva); else pass_cnt++;
        total_cnt++; if (dv_cnt[0] - d0 != 1) $display("FAIL lb_dvalid_count: got %0d need 1", dv_cnt[0] - d0); else pass_cnt++;
        total_cnt++; if (dout[0] !== 8'hA5) $display("FAIL lb_data: got %h need a5", dout[0]); else pass_cnt++;
        total_cnt++; if (pe_cnt[0] + fe_cnt[0] - e0 != 0) $display("FAIL lb_errors: got %0d need 0", pe_cnt[0] + fe_cnt[0] - e0); else pass_cnt++;
        loop[0] = 1'b0;
    endtask

    task automatic test_parity_loopback();
        int c, lr, da, dva, d1, e1, d2, e2;
        logic sv, rd, rp;
        // Even parity, 0x07 has three ones: parity bit 1, bit on the line in cycles 73..80.
        loop[1] = 1'b1;
        d1 = dv_cnt[1];
        e1 = pe_cnt[1] + fe_cnt[1];
        accept(1, 8'h07, c);
        watch(1, 100, 77, lr, sv, da, rd, rp, dva);
        total_cnt++; if (sv !== 1'b1) $display("FAIL even_parity_bit: got %b need 1", sv); else pass_cnt++;
        total_cnt++; if (da != 89) $display("FAIL even_done_cycle: got %0d need 89", da); else pass_cnt++;
        total_cnt++; if (dv_cnt[1] - d1 != 1) $display("FAIL even_dvalid_count: got %0d need 1", dv_cnt[1] - d1); else pass_cnt++;
        total_cnt++; if (dout[1] !== 8'h07) $display("FAIL even_data: got %h need 07", dout[1]); else pass_cnt++;
        total_cnt++; if (pe_cnt[1] + fe_cnt[1] - e1 != 0) $display("FAIL even_errors: got %0d need 0", pe_cnt[1] + fe_cnt[1] - e1); else pass_cnt++;
        loop[1] = 1'b0;
        // Odd parity: parity bit 0.
        loop[2] = 1'b1;
        d2 = dv_cnt[2];
        e2 = pe_cnt[2] + fe_cnt[2];
        accept(2, 8'h07, c);
        watch(2, 100, 77, lr, sv, da, rd, rp, dva);
        total_cnt++; if (sv !== 1'b0) $display("FAIL odd_parity_bit: got %b need 0", sv); else pass_cnt++;
        total_cnt++; if (dv_cnt[2] - d2 != 1) $display("FAIL odd_dvalid_count: got %0d need 1", dv_cnt[2] - d2); else pass_cnt++;
        total_cnt++; if (dout[2] !== 8'h07) $display("FAIL odd_data: got %h need 07", dout[2]); else pass_cnt++;
        total_cnt++; if (pe_cnt[2] + fe_cnt[2] - e2 != 0) $display("FAIL odd_errors: got %0d need 0", pe_cnt[2] + fe_cnt[2] - e2); else pass_cnt++;
        loop[2] = 1'b0;
    endtask

    task automatic test_parity_error();
        int d1, p1, f1;
        wait_cyc(5);
        d1 = dv_cnt[1];
        p1 = pe_cnt[1];
        f1 = fe_cnt[1];
        // 0x03 under even parity needs parity bit 0; send 1 instead.
        drive_bits(1, {5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
        drv[1] = 1'b1;
        wait_cyc(20);
        total_cnt++; if (pe_cnt[1] - p1 != 1) $display("FAIL perr_pulse_count: got %0d need 1", pe_cnt[1] - p1); else pass_cnt++;
        total_cnt++; if (dv_cnt[1] - d1 != 0) $display("FAIL perr_dvalid_count: got %0d need 0", dv_cnt[1] - d1); else pass_cnt++;
        total_cnt++; if (dout[1] !== 8'h07) $display("FAIL perr_data_held: got %h need 07", dout[1]); else pass_cnt++;
        total_cnt++; if (fe_cnt[1] - f1 != 0) $display("FAIL perr_frame_err: got %0d need 0", fe_cnt[1] - f1); else pass_cnt++;
    endtask

    task automatic test_framing_break();
        int d0, f0, p0;
        d0 = dv_cnt[0];
        f0 = fe_cnt[0];
        p0 = pe_cnt[0];
        // 0x55 with a low stop bit, then the line held low as a break.
        drive_bits(0, {6'b0, 1'b0, 8'h55, 1'b0}, 10);
        drv[0] = 1'b0;
        wait_cyc(50);
        drv[0] = 1'b1;
        wait_cyc(20);
        total_cnt++; if (fe_cnt[0] - f0 != 1) $display("FAIL ferr_pulse_count: got %0d need 1", fe_cnt[0] - f0); else pass_cnt++;
        total_cnt++; if (dv_cnt[0] - d0 != 0) $display("FAIL ferr_dvalid_count: got %0d need 0", dv_cnt[0] - d0); else pass_cnt++;
        total_cnt++; if (pe_cnt[0] - p0 != 0) $display("FAIL ferr_parity_err: got %0d need 0", pe_cnt[0] - p0); else pass_cnt++;
        d0 = dv_cnt[0];
        f0 = fe_cnt[0];
        drive_bits(0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10);
        drv[0] = 1'b1;
        wait_cyc(20);
        total_cnt++; if (dv_cnt[0] - d0 != 1) $display("FAIL after_break_dvalid: got %0d need 1", dv_cnt[0] - d0); else pass_cnt++;
        total_cnt++; if (dout[0] !== 8'h3C) $display("FAIL after_break_data: got %h need 3c", dout[0]); else pass_cnt++;
        total_cnt++; if (fe_cnt[0] - f0 != 0) $display("FAIL after_break_frame_err: got %0d need 0", fe_cnt[0] - f0); else pass_cnt++;
    endtask

    task automatic test_false_start();
        int d0, e0;
        d0 = dv_cnt[0];
        e0 = pe_cnt[0] + fe_cnt[0];
        drv[0] = 1'b0;
        wait_cyc(2);
        drv[0] = 1'b1;
        wait_cyc(30);
        total_cnt++; if (dv_cnt[0] - d0 != 0) $display("FAIL glitch_dvalid: got %0d need 0", dv_cnt[0] - d0); else pass_cnt++;
        total_cnt++; if (pe_cnt[0] + fe_cnt[0] - e0 != 0) $display("FAIL glitch_errors: got %0d need 0", pe_cnt[0] + fe_cnt[0] - e0); else pass_cnt++;
        total_cnt++; if (rx_st[0] !== 3'd0) $display("FAIL glitch_rx_idle: got state %0d need 0", rx_st[0]); else pass_cnt++;
        drive_bits(0, {6'b0, 1'b1, 8'h81, 1'b0}, 10);
        drv[0] = 1'b1;
        wait_cyc(20);
        total_cnt++; if (dv_cnt[0] - d0 != 1) $display("FAIL post_glitch_dvalid: got %0d need 1", dv_cnt[0] - d0); else pass_cnt++;
        total_cnt++; if (dout[0] !== 8'h81) $display("FAIL post_glitch_data: got %h need 81", dout[0]); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int c1, c2, d3, e3;
        logic [7:0] g0, g1;
        loop[3] = 1'b1;
        got_d.delete();
        d3 = dv_cnt[3];
        e3 = pe_cnt[3] + fe_cnt[3];
        accept(3, 8'h11, c1);
        repeat (20) @(negedge clk);
        total_cnt++; if (rdy[3] !== 1'b0) $display("FAIL busy_rdy: got %b need 0", rdy[3]); else pass_cnt++;
        // Request while busy, with new data on i_data: must be dropped.
        din[3]   = 8'h99;
        tx_en[3] = 1'b1;
        wait_cyc(1);
        tx_en[3] = 1'b0;
        accept(3, 8'h22, c2);
        // 11-bit frame of 88 cycles plus one cycle in IDLE.
        total_cnt++; if (c2 - c1 != 89) $display("FAIL b2b_period: got %0d need 89", c2 - c1); else pass_cnt++;
        wait_cyc(250);
        g0 = (got_d.size() > 0) ? got_d[0] : 8'hxx;
        g1 = (got_d.size() > 1) ? got_d[1] : 8'hxx;
        total_cnt++; if (dv_cnt[3] - d3 != 2) $display("FAIL b2b_dvalid_count: got %0d need 2", dv_cnt[3] - d3); else pass_cnt++;
        total_cnt++; if (g0 !== 8'h11) $display("FAIL b2b_first: got %h need 11", g0); else pass_cnt++;
        total_cnt++; if (g1 !== 8'h22) $display("FAIL b2b_second: got %h need 22", g1); else pass_cnt++;
        total_cnt++; if (pe_cnt[3] + fe_cnt[3] - e3 != 0) $display("FAIL b2b_errors: got %0d need 0", pe_cnt[3] + fe_cnt[3] - e3); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        int c, d3, e3;
        accept(3, 8'h5A, c);
        wait_cyc(30);
        total_cnt++; if (tx_st[3] !== 3'd2) $display("FAIL mid_frame_in_data: got state %0d need 2", tx_st[3]); else pass_cnt++;
        d3 = dv_cnt[3];
        e3 = pe_cnt[3] + fe_cnt[3];
        reset = 1'b1;
        wait_cyc(1);
        total_cnt++; if (tx[3] !== 1'b1) $display("FAIL rst_mid_tx: got %b need 1", tx[3]); else pass_cnt++;
        total_cnt++; if (rdy[3] !== 1'b1) $display("FAIL rst_mid_rdy: got %b need 1", rdy[3]); else pass_cnt++;
        total_cnt++; if (rx_st[3] !== 3'd0) $display("FAIL rst_mid_rx_state: got %0d need 0", rx_st[3]); else pass_cnt++;
        total_cnt++; if (dout[3] !== 8'h00) $display("FAIL rst_mid_data: got %h need 00", dout[3]); else pass_cnt++;
        reset = 1'b0;
        wait_cyc(150);
        total_cnt++; if (dv_cnt[3] - d3 != 0) $display("FAIL rst_mid_dvalid: got %0d need 0", dv_cnt[3] - d3); else pass_cnt++;
        total_cnt++; if (pe_cnt[3] + fe_cnt[3] - e3 != 0) $display("FAIL rst_mid_errors: got %0d need 0", pe_cnt[3] + fe_cnt[3] - e3); else pass_cnt++;
        total_cnt++; if (tx[3] !== 1'b1) $display("FAIL rst_mid_line_idle: got %b need 1", tx[3]); else pass_cnt++;
        loop[3] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) din[k] = 8'h00;
        test_reset();
        test_loopback_8n1();
        test_parity_loopback();
        test_parity_error();
        test_framing_break();
        test_false_start();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
